// File: rtl/d_mem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package d_mem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} mem_size_t;

  typedef enum logic {IDLE, BEAT1} lsu_state_t;

  // Access width in bytes; the illegal encoding is rejected separately.
  function automatic logic [2:0] size_to_bytes(input mem_size_t size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Unshifted lane mask covering the access width.
  function automatic logic [3:0] size_to_lanes(input mem_size_t size);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001;
      SZ_H:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Mask an LSB-justified load to its width, then sign- or zero-extend.
  function automatic logic [31:0] load_extend(input logic [31:0] raw, input mem_size_t size,
                                              input logic sign_ext);
    logic [31:0] r;
    case (size)
      SZ_B:    r = sign_ext ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
      SZ_H:    r = sign_ext ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/d_mem_sync.sv
// Single-port byte-lane RAM with synchronous write and registered read.
module d_mem_sync #(
  parameter  int unsigned MEM_SIZE_WORDS = 256,
  localparam int unsigned AW = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          wr_en,
  input  logic [3:0]    byte_en,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [MEM_SIZE_WORDS];

  // Read returns the pre-write contents when read and write hit the same edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && byte_en[i]) begin
        mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    rd_data <= mem[addr];
  end

endmodule

// File: rtl/d_mem_lsu.sv
// Load/store front end for the data RAM: request handshake, range/alignment
// checking, two-beat split of word-crossing accesses and registered responses.
module d_mem_lsu
  import d_mem_pkg::*;
#(
  parameter int unsigned MEM_SIZE_BYTES   = 1024,
  parameter int unsigned MEM_SIZE_WORDS   = MEM_SIZE_BYTES / 4,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr_en,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wr_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_rd_data,
  output logic        rsp_err
);

  localparam int unsigned AW = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;

  lsu_state_t  state;
  mem_size_t   size;
  logic [2:0]  nbytes;
  logic [1:0]  off;
  logic [32:0] last_byte;
  logic        acc_err;
  logic        acc_cross;
  logic        accept;
  logic [7:0]  lane_mask;
  logic [63:0] wd64;

  logic [AW-1:0] b1_addr;
  logic [3:0]    b1_be;
  logic [31:0]   b1_data;
  logic          b1_wr;

  logic        p_valid;
  logic        p_err;
  logic        p_wr;
  logic        p_signed;
  logic        p_cross;
  mem_size_t   p_size;
  logic [1:0]  p_off;
  logic [31:0] hold;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wd;
  logic [31:0]   ram_rd;
  logic [63:0]   ld_pair;
  logic [31:0]   ld_raw;

  // Request decode: the last byte is formed at 33 bits so high addresses cannot wrap.
  always_comb begin
    size      = mem_size_t'(req_size);
    nbytes    = size_to_bytes(size);
    off       = req_addr[1:0];
    last_byte = {1'b0, req_addr} + 33'(nbytes) - 33'd1;
    acc_cross = (3'(off) + nbytes) > 3'd4;
    acc_err   = (size == SZ_BAD) || (last_byte >= 33'(MEM_SIZE_BYTES)) ||
                (!ALLOW_MISALIGNED && ((off & 2'(nbytes - 3'd1)) != 2'b00));
    lane_mask = 8'(size_to_lanes(size)) << off;
    wd64      = 64'(req_wr_data) << {off, 3'b000};
  end

  assign req_ready = !rst && (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Beat1 replays the registered upper half of the shifted request.
  always_comb begin
    if (state == BEAT1) begin
      ram_addr = b1_addr;
      ram_we   = b1_wr;
      ram_be   = b1_be;
      ram_wd   = b1_data;
    end else begin
      ram_addr = req_addr[AW+1:2];
      ram_we   = accept && req_wr_en && !acc_err;
      ram_be   = lane_mask[3:0];
      ram_wd   = wd64[31:0];
    end
  end

  d_mem_sync #(.MEM_SIZE_WORDS(MEM_SIZE_WORDS)) u_ram (
    .clk     (clk),
    .addr    (ram_addr),
    .wr_en   (ram_we),
    .byte_en (ram_be),
    .wr_data (ram_wd),
    .rd_data (ram_rd)
  );

  // Crossing loads stitch the held beat0 word under the beat1 word, then shift down.
  always_comb begin
    ld_pair = p_cross ? {ram_rd, hold} : {32'd0, ram_rd};
    ld_raw  = 32'(ld_pair >> {p_off, 3'b000});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      p_valid     <= 1'b0;
      p_err       <= 1'b0;
      p_wr        <= 1'b0;
      p_signed    <= 1'b0;
      p_cross     <= 1'b0;
      p_size      <= SZ_W;
      p_off       <= 2'd0;
      hold        <= 32'd0;
      b1_addr     <= '0;
      b1_be       <= 4'd0;
      b1_data     <= 32'd0;
      b1_wr       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rd_data <= 32'd0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == BEAT1) begin
        hold    <= ram_rd;
        p_valid <= 1'b1;
        state   <= IDLE;
      end else begin
        if (p_valid) begin
          rsp_valid   <= 1'b1;
          rsp_err     <= p_err;
          rsp_rd_data <= (p_err || p_wr) ? 32'd0 : load_extend(ld_raw, p_size, p_signed);
        end
        p_valid <= accept && !(acc_cross && !acc_err);
        if (accept) begin
          p_err    <= acc_err;
          p_wr     <= req_wr_en;
          p_signed <= req_signed;
          p_cross  <= acc_cross && !acc_err;
          p_size   <= size;
          p_off    <= off;
          b1_addr  <= req_addr[AW+1:2] + AW'(1);
          b1_be    <= lane_mask[7:4];
          b1_data  <= wd64[63:32];
          b1_wr    <= req_wr_en;
          if (acc_cross && !acc_err) begin
            state <= BEAT1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_d_mem_lsu.sv
// Directed bench for d_mem_lsu: one instance allowing misaligned splits, one rejecting them.
module tb_d_mem_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_wr_en;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wr_data;

  logic        ready_a, valid_a, err_a;
  logic [31:0] rd_a;
  logic        ready_b, valid_b, err_b;
  logic [31:0] rd_b;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, BAD = 2'b11;

  d_mem_lsu #(.MEM_SIZE_BYTES(1024), .MEM_SIZE_WORDS(256), .ALLOW_MISALIGNED(1'b1)) u_lsu (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a), .req_addr(req_addr),
    .req_wr_en(req_wr_en), .req_size(req_size), .req_signed(req_signed),
    .req_wr_data(req_wr_data), .rsp_valid(valid_a), .rsp_rd_data(rd_a), .rsp_err(err_a)
  );

  d_mem_lsu #(.MEM_SIZE_BYTES(1024), .MEM_SIZE_WORDS(256), .ALLOW_MISALIGNED(1'b0)) u_lsu_aligned (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b), .req_addr(req_addr),
    .req_wr_en(req_wr_en), .req_size(req_size), .req_signed(req_signed),
    .req_wr_data(req_wr_data), .rsp_valid(valid_b), .rsp_rd_data(rd_b), .rsp_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge, then wait (bounded) for its response.
  task automatic do_req(input bit sel, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic sg, input logic [31:0] d, output logic [31:0] rd,
                        output logic er, output int lat, output logic busy);
    req_valid = 1'b1; req_wr_en = wr; req_size = sz; req_addr = a;
    req_signed = sg; req_wr_data = d;
    @(negedge clk);
    req_valid = 1'b0;
    busy = !(sel ? ready_b : ready_a);
    lat = 0; rd = 32'd0; er = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (sel ? valid_b : valid_a) begin
        lat = i;
        rd  = sel ? rd_b : rd_a;
        er  = sel ? err_b : err_a;
        break;
      end
    end
  endtask

  task automatic req_chk(input string tag, input bit sel, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic sg, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                         input logic exp_busy);
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        busy;
    do_req(sel, wr, sz, a, sg, d, rd, er, lat, busy);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rd"}, rd, exp_rd);
    chk({tag, ".err"}, 32'(er), 32'(exp_err));
    chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  logic [31:0] s_addr [5] = '{32'h14, 32'h14, 32'h10, 32'h14, 32'h10};
  logic        s_wr   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] s_data [5] = '{32'h1111_1111, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] s_exp  [5] = '{32'h0, 32'h1111_1111, 32'hDEAD_BEEF, 32'h1111_1111, 32'hDEAD_BEEF};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_wr_en = 1'b0;
    req_size = W; req_signed = 1'b0; req_wr_data = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset.ready", 32'(ready_a), 32'd0);
    chk("reset.rsp_valid", 32'(valid_a), 32'd0);
    chk("reset.rd", rd_a, 32'd0);
    chk("reset.err", 32'(err_a), 32'd0);
    rst = 1'b0;
    #1;
    chk("release.ready", 32'(ready_a), 32'd1);
    @(negedge clk);

    req_chk("sw10",   0, 1'b1, W, 32'h10, 1'b0, 32'hDEAD_BEEF, 32'h0,         1'b0, 1, 1'b0);
    req_chk("lw10",   0, 1'b0, W, 32'h10, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, 1'b0);
    req_chk("lb13",   0, 1'b0, B, 32'h13, 1'b1, 32'h0,         32'hFFFF_FFDE, 1'b0, 1, 1'b0);
    req_chk("lbu13",  0, 1'b0, B, 32'h13, 1'b0, 32'h0,         32'h0000_00DE, 1'b0, 1, 1'b0);
    req_chk("lhu12",  0, 1'b0, H, 32'h12, 1'b0, 32'h0,         32'h0000_DEAD, 1'b0, 1, 1'b0);

    req_chk("sh23",   0, 1'b1, H, 32'h23, 1'b0, 32'h0000_CAFE, 32'h0,         1'b0, 2, 1'b1);
    req_chk("lbu23",  0, 1'b0, B, 32'h23, 1'b0, 32'h0,         32'h0000_00FE, 1'b0, 1, 1'b0);
    req_chk("lbu24",  0, 1'b0, B, 32'h24, 1'b0, 32'h0,         32'h0000_00CA, 1'b0, 1, 1'b0);
    req_chk("lh23",   0, 1'b0, H, 32'h23, 1'b1, 32'h0,         32'hFFFF_CAFE, 1'b0, 2, 1'b1);

    req_chk("sw3fc",  0, 1'b1, W, 32'h3FC, 1'b0, 32'h1234_5678, 32'h0,        1'b0, 1, 1'b0);
    req_chk("lw3fe",  0, 1'b0, W, 32'h3FE, 1'b0, 32'h0,         32'h0,        1'b1, 1, 1'b0);
    req_chk("sw3fe",  0, 1'b1, W, 32'h3FE, 1'b0, 32'hAAAA_AAAA, 32'h0,        1'b1, 1, 1'b0);
    req_chk("lw3fc",  0, 1'b0, W, 32'h3FC, 1'b0, 32'h0,         32'h1234_5678, 1'b0, 1, 1'b0);
    req_chk("lh3ff",  0, 1'b0, H, 32'h3FF, 1'b0, 32'h0,         32'h0,        1'b1, 1, 1'b0);
    req_chk("lb3ff",  0, 1'b0, B, 32'h3FF, 1'b1, 32'h0,         32'h0000_0012, 1'b0, 1, 1'b0);
    req_chk("bad0",   0, 1'b0, BAD, 32'h0, 1'b0, 32'h0,         32'h0,        1'b1, 1, 1'b0);

    req_chk("al.lw11", 1, 1'b0, W, 32'h11, 1'b0, 32'h0,        32'h0,         1'b1, 1, 1'b0);
    req_chk("al.lh12", 1, 1'b0, H, 32'h12, 1'b0, 32'h0,        32'h0000_DEAD, 1'b0, 1, 1'b0);
    @(negedge clk);

    // Store then loads on consecutive cycles: one response per cycle, store visible next cycle.
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        req_valid = 1'b1; req_wr_en = s_wr[i]; req_size = W; req_addr = s_addr[i];
        req_signed = 1'b0; req_wr_data = s_data[i];
        chk($sformatf("stream.ready%0d", i), 32'(ready_a), 32'd1);
      end else begin
        req_valid = 1'b0;
      end
      if (i >= 2) begin
        chk($sformatf("stream.valid%0d", i - 2), 32'(valid_a), 32'd1);
        chk($sformatf("stream.rd%0d", i - 2), rd_a, s_exp[i-2]);
      end
      @(negedge clk);
    end
    chk("stream.idle", 32'(valid_a), 32'd0);

    // Reset in the middle of a crossing load abandons it without a response.
    req_valid = 1'b1; req_wr_en = 1'b0; req_size = W; req_addr = 32'h21; req_signed = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort.beat1_ready", 32'(ready_a), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort.rst_ready", 32'(ready_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.release_ready", 32'(ready_a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort.no_rsp%0d", i), 32'(valid_a), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
